// File: rtl/booth_pkg.sv
// Shared types and widths for the Booth product accumulator.
// Optional build macro: BOOTH_ACC_SATURATE_EN (used by booth_sat_add).
package booth_pkg;

  localparam int PROD_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed ACC_W adder with overflow flag.
// Build macro BOOTH_ACC_SATURATE_EN clamps the sum on overflow; otherwise it wraps.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] raw;

  assign raw = a + b;

  // Overflow: operands share a sign that the result does not.
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    sum = raw;
`ifdef BOOTH_ACC_SATURATE_EN
    if (ovf) begin
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/booth_accumulator.sv
// Sums N_TERMS signed Booth products per job with valid/ready framing and sticky overflow.
// Build macro BOOTH_ACC_SATURATE_EN selects clamping instead of wrapping in booth_sat_add.
module booth_accumulator
  import booth_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] prod,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic                    accept;
  logic                    last_beat;

  assign prod_ext  = ACC_W'(prod);
  assign accept    = (state == ACCUM) && in_valid;
  assign last_beat = accept && (cnt == LAST_CNT);

  booth_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (add_ovf)
  );

  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ACCUM;
      ACCUM:   if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: cleared by start in IDLE, advanced only on accepted beats, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if ((state == IDLE) && start) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      ovf <= ovf | add_ovf;
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_booth_accumulator.sv
// Directed scoreboard bench for booth_accumulator (N_TERMS=4, ACC_W=16).
// Expected overflow result follows BOOTH_ACC_SATURATE_EN.
module tb_booth_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] prod;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] acc_out;
  logic               ovf;

  typedef struct {
    logic signed [15:0] acc;
    logic               ovf;
  } res_t;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  booth_accumulator #(.N_TERMS(4), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] p);
    int budget = 0;
    in_valid = 1'b1;
    prod     = p;
    while (!in_ready && budget < 20) begin
      tick(1);
      budget++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag);
    res_t e;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_acc"}, acc_out, e.acc);
      check({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check({tag, "_idle_out_valid"}, out_valid, 0);
    check({tag, "_idle_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic signed [15:0] held;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; prod = '0; out_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc_out, 0);
    check("rst_ovf", ovf, 0);

    // Basic job, back-to-back beats
    start_job();
    check("t1_accum_in_ready", in_ready, 1);
    exp_q.push_back('{acc: 16'sd257, ovf: 1'b0});
    send(16'sd100);
    check("t1_acc_after_beat1", acc_out, 100);
    send(16'sd200);
    send(-16'sd50);
    check("t1_not_done_after_3", out_valid, 0);
    send(16'sd7);
    expect_result("t1");
    release_result("t1");

    // Booth products with in_valid gaps
    start_job();
    exp_q.push_back('{acc: -16'sd987, ovf: 1'b0});
    send(-16'sd3198);
    tick(2);
    send(16'sd4096);
    send(-16'sd1584);
    tick(3);
    check("t2_gap_in_ready", in_ready, 1);
    check("t2_gap_out_valid", out_valid, 0);
    check("t2_gap_acc", acc_out, 3198 * -1 + 4096 - 1584);
    send(-16'sd301);
    expect_result("t2");
    release_result("t2");

    // Overflow in a 16-bit accumulator
    start_job();
`ifdef BOOTH_ACC_SATURATE_EN
    exp_q.push_back('{acc: 16'sd32767, ovf: 1'b1});
`else
    exp_q.push_back('{acc: 16'sd0, ovf: 1'b1});
`endif
    for (int i = 0; i < 4; i++) send(16'sd16384);
    expect_result("t3");

    // Backpressure in DONE with start asserted
    held  = acc_out;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t4_hold_out_valid", out_valid, 1);
      check("t4_hold_acc", acc_out, held);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_ovf", ovf, 1);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    start     = 1'b0;
    check("t4_idle_out_valid", out_valid, 0);
    check("t4_start_ignored_in_ready", in_ready, 0);

    // Start from IDLE clears sticky ovf; start during ACCUM is ignored
    start_job();
    check("t6_ovf_cleared", ovf, 0);
    check("t6_acc_cleared", acc_out, 0);
    exp_q.push_back('{acc: 16'sd26, ovf: 1'b0});
    send(16'sd5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6_no_clear_acc", acc_out, 5);
    check("t6_still_accum", in_ready, 1);
    send(16'sd6);
    send(16'sd7);
    send(16'sd8);
    expect_result("t6");
    release_result("t6");

    // Reset mid-job after an overflowing pair
    start_job();
    send(16'sd30000);
    send(16'sd30000);
    check("t5_ovf_set", ovf, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_acc", acc_out, 0);
    check("t5_rst_ovf", ovf, 0);
    start_job();
    exp_q.push_back('{acc: 16'sd10, ovf: 1'b0});
    for (int i = 1; i <= 4; i++) send(16'(i));
    expect_result("t5");
    release_result("t5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
